// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction image loader.
// The image is a 2-byte little-endian word count followed by little-endian 32-bit words.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Best-case cycles from entering LEN_LO to entering DONE for an n-word image.
  function automatic int unsigned min_load_cycles(input int unsigned n_words);
    return HDR_BYTES + (BYTES_PER_WORD + 1) * n_words;
  endfunction

  function automatic logic [31:0] word_to_byte_addr(input logic [15:0] word_idx);
    return {14'b0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Collects BYTES_PER_WORD stream bytes into a little-endian word, first byte in the LSB.
// word presents the merged value combinationally, so it is complete in the cycle word_done pulses.
module byte_assembler
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    if (in_valid) begin
      word[{cnt_q, 3'b000} +: 8] = in_byte;
    end
  end

  assign word_done = in_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (in_valid) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Streams a counted image of little-endian words into the fetch stage's instruction memory,
// holding the fetch stage in load mode (we) for the duration of the load.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] load_addr,
  output logic [31:0] load_data,
  output logic        load_strobe,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       hdr_count;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [31:0]       load_addr_q, load_addr_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              rx_ready_q, we_q, busy_q, done_q, error_q, load_strobe_q;

  logic              xfer;
  logic              asm_clr;
  logic              asm_valid;
  logic              asm_word_done;
  logic [31:0]       asm_word;

  assign xfer      = rx_valid && rx_ready_q;
  assign asm_valid = xfer && (state_q == DATA);
  assign hdr_count = {rx_data, count_q[7:0]};

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .in_valid  (asm_valid),
    .in_byte   (rx_data),
    .word_done (asm_word_done),
    .word      (asm_word)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    asm_clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          word_idx_d = '0;
          asm_clr    = 1'b1;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          count_d[7:0] = rx_data;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          count_d = hdr_count;
          if (hdr_count > 16'(DEPTH_WORDS)) begin
            state_d = ERR;
          end else if (hdr_count == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Address and data are latched on the last byte so they are valid throughout WRITE.
        if (asm_word_done) begin
          state_d     = WRITE;
          load_addr_d = word_to_byte_addr(16'(word_idx_q));
          load_data_d = asm_word;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (16'(word_idx_d) == count_q) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      word_idx_q    <= '0;
      load_addr_q   <= '0;
      load_data_q   <= '0;
      rx_ready_q    <= 1'b0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      load_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_idx_q    <= word_idx_d;
      load_addr_q   <= load_addr_d;
      load_data_q   <= load_data_d;
      rx_ready_q    <= (state_d inside {LEN_LO, LEN_HI, DATA});
      we_q          <= (state_d inside {LEN_LO, LEN_HI, DATA, WRITE});
      busy_q        <= (state_d inside {LEN_LO, LEN_HI, DATA, WRITE});
      done_q        <= (state_d == DONE);
      error_q       <= (state_d == ERR);
      load_strobe_q <= (state_d == WRITE);
    end
  end

  assign rx_ready    = rx_ready_q;
  assign we          = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign load_strobe = load_strobe_q;
  assign load_addr   = load_addr_q;
  assign load_data   = load_data_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: loads push expected (addr, data) writes,
// a negedge monitor pops them on every load_strobe.
module tb_instruction_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, load_strobe, busy, done, error;
  logic [31:0] load_addr, load_data;

  instruction_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .we          (we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_strobe (load_strobe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int unsigned cyc_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && load_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got addr 0x%08h data 0x%08h, expected no write",
                 load_addr, load_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", load_addr, mon_e[63:32]);
        check("strobe_data", load_data, mon_e[31:0]);
      end
    end
  end

  task automatic do_start(output int unsigned t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc_cnt;
    check("start_we", {31'b0, we}, 32'd1);
    check("start_rdy", {31'b0, rx_ready}, 32'd1);
    check("start_done_clr", {31'b0, done}, 32'd0);
    check("start_err_clr", {31'b0, error}, 32'd0);
  endtask

  // mode 0: rx_valid always high, 1: toggled every other cycle, 2: random gaps.
  task automatic send_bytes(input logic [7:0] bytes[$], input int mode, input int start_at,
                            output bit ok);
    int idx = 0;
    int cyc = 0;
    bit took;
    while (idx < bytes.size() && cyc < 5000) begin
      rx_data = bytes[idx];
      case (mode)
        0:       rx_valid = 1'b1;
        1:       rx_valid = cyc[0];
        default: rx_valid = ($urandom_range(0, 3) != 0);
      endcase
      start = (idx == start_at);
      took  = rx_valid && rx_ready;
      @(negedge clk);
      cyc++;
      if (took) idx++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    ok       = (idx == bytes.size());
  endtask

  task automatic push_word_bytes(input logic [31:0] w, inout logic [7:0] bytes[$]);
    logic [31:0] s;
    s = w;
    for (int k = 0; k < 4; k++) begin
      bytes.push_back(s[7:0]);
      s = s >> 8;
    end
  endtask

  task automatic run_load(input logic [15:0] cnt, input logic [31:0] words[$], input int mode,
                          input int start_at, input bit chk_lat);
    logic [7:0]  bytes[$];
    logic [15:0] c;
    bit          ok;
    bit          accept;
    int unsigned t0;
    int unsigned exp_lat;
    c      = cnt;
    accept = (int'(cnt) <= DEPTH);
    bytes.push_back(c[7:0]);
    bytes.push_back(c[15:8]);
    if (accept) begin
      for (int i = 0; i < int'(cnt); i++) begin
        exp_q.push_back({32'(i * 4), words[i]});
        push_word_bytes(words[i], bytes);
      end
    end
    exp_lat = accept ? 2 + 5 * int'(cnt) : 2;
    do_start(t0);
    send_bytes(bytes, mode, start_at, ok);
    if (!ok) begin
      checks++;
      $display("FAIL stream_timeout: got stalled stream, expected all %0d bytes accepted", bytes.size());
    end
    for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
    if (!(done || error)) begin
      checks++;
      $display("FAIL finish_timeout: got done=0 error=0, expected completion within 20 cycles");
    end
    if (chk_lat) check("latency", cyc_cnt - t0, exp_lat);
    check("done", {31'b0, done}, {31'b0, accept});
    check("error", {31'b0, error}, {31'b0, !accept});
    check("we_after", {31'b0, we}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("rdy_after", {31'b0, rx_ready}, 32'd0);
    check("writes_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  function automatic void rand_words(input int n, output logic [31:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endfunction

  initial begin
    logic [31:0] fixed_w[$];
    logic [31:0] w[$];
    logic [7:0]  bytes[$];
    int unsigned t0;
    bit          ok;
    int          n;

    fixed_w = {32'h00000013, 32'h00100093};

    #1 rst = 1'b0;
    #2;
    check("rst_rdy", {31'b0, rx_ready}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, error}, 32'd0);
    check("rst_strobe", {31'b0, load_strobe}, 32'd0);
    check("rst_addr", load_addr, 32'd0);
    check("rst_data", load_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_load(16'd2, fixed_w, 0, -1, 1'b1);
    run_load(16'd0, fixed_w, 0, -1, 1'b1);
    run_load(16'd65, fixed_w, 0, -1, 1'b1);
    run_load(16'd2, fixed_w, 1, -1, 1'b0);

    // Abort during the second word: first word is written, then reset clears everything.
    w = {32'hDEADBEEF, 32'h0BADF00D};
    bytes.delete();
    bytes.push_back(8'h02);
    bytes.push_back(8'h00);
    push_word_bytes(w[0], bytes);
    bytes.push_back(8'h0D);
    bytes.push_back(8'hF0);
    exp_q.push_back({32'h0, w[0]});
    do_start(t0);
    send_bytes(bytes, 0, -1, ok);
    check("abort_word0_written", exp_q.size(), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_we", {31'b0, we}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rdy", {31'b0, rx_ready}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_err", {31'b0, error}, 32'd0);
    check("abort_strobe", {31'b0, load_strobe}, 32'd0);
    check("abort_addr", load_addr, 32'd0);
    check("abort_data", load_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_load(16'd2, fixed_w, 0, -1, 1'b1);

    rand_words(3, w);
    run_load(16'd3, w, 0, 4, 1'b1);
    rand_words(2, w);
    run_load(16'd2, w, 2, -1, 1'b0);

    rand_words(64, w);
    run_load(16'd64, w, 0, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      rand_words(n, w);
      run_load(16'(n), w, 2, -1, 1'b0);
    end
    run_load(16'($urandom_range(66, 65535)), fixed_w, 2, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
